// File: rtl/vga_apb_regif.sv
// vga_apb_regif: APB3 register interface for the VGA controller.
// Ports: APB slave (psel/penable/pwrite/paddr/pwdata -> prdata/pready/pslverr),
//        reg_wr_en/reg_wdata strobes to CTRL/HTIM/VTIM/BASE, *_q read-back,
//        frame_start/fifo_underflow events, irq level interrupt.
module vga_apb_regif #(
   parameter int DATA_WIDTH = 32,
   parameter int ADDR_WIDTH = 8
) (
   input  logic                  clk,
   input  logic                  rst_n,
   input  logic                  psel,
   input  logic                  penable,
   input  logic                  pwrite,
   input  logic [ADDR_WIDTH-1:0] paddr,
   input  logic [DATA_WIDTH-1:0] pwdata,
   output logic [DATA_WIDTH-1:0] prdata,
   output logic                  pready,
   output logic                  pslverr,
   output logic [3:0]            reg_wr_en,
   output logic [DATA_WIDTH-1:0] reg_wdata,
   input  logic [DATA_WIDTH-1:0] ctrl_q,
   input  logic [DATA_WIDTH-1:0] htim_q,
   input  logic [DATA_WIDTH-1:0] vtim_q,
   input  logic [DATA_WIDTH-1:0] base_q,
   input  logic                  frame_start,
   input  logic                  fifo_underflow,
   output logic                  irq
);

   typedef enum logic [1:0] {
      S_IDLE,
      S_WAIT,
      S_DONE
   } state_t;

   state_t                state;
   logic [ADDR_WIDTH-1:0] addr_q;
   logic                  wr_q;
   logic [DATA_WIDTH-1:0] wdata_q;
   logic [15:0]           frame_cnt;
   logic [1:0]            int_stat;
   logic [1:0]            int_en;

   logic                  err;
   logic                  wr_ok;
   logic [2:0]            idx;
   logic [7:0]            sel;
   logic [DATA_WIDTH-1:0] rdata;
   logic [1:0]            int_clr;
   logic                  en_wr;

   // Decode is done purely on the values captured at setup.
   assign idx   = addr_q[4:2];
   assign sel   = 8'b1 << idx;
   assign err   = (addr_q > ADDR_WIDTH'(24))
               || (addr_q[1:0] != 2'b00)
               || (wr_q && sel[4]);
   assign wr_ok = wr_q && !err;

   always_comb begin
      rdata = '0;
      unique case (1'b1)
         sel[0]:  rdata = ctrl_q;
         sel[1]:  rdata = htim_q;
         sel[2]:  rdata = vtim_q;
         sel[3]:  rdata = base_q;
         sel[4]:  rdata = DATA_WIDTH'(frame_cnt);
         sel[5]:  rdata = DATA_WIDTH'(int_stat);
         sel[6]:  rdata = DATA_WIDTH'(int_en);
         default: rdata = '0;
      endcase
   end

   // Internal register writes take effect at the end of the DONE cycle.
   assign int_clr = (state == S_DONE && wr_ok && sel[5])
                  ? wdata_q[1:0] : 2'b00;
   assign en_wr   = (state == S_DONE) && wr_ok && sel[6];

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state     <= S_IDLE;
         addr_q    <= '0;
         wr_q      <= 1'b0;
         wdata_q   <= '0;
         pready    <= 1'b0;
         pslverr   <= 1'b0;
         prdata    <= '0;
         reg_wr_en <= 4'b0000;
         reg_wdata <= '0;
      end else begin
         reg_wr_en <= 4'b0000;
         reg_wdata <= '0;
         unique case (state)
            S_IDLE: begin
               pready  <= 1'b0;
               pslverr <= 1'b0;
               prdata  <= '0;
               if (psel && !penable) begin
                  addr_q  <= paddr;
                  wr_q    <= pwrite;
                  wdata_q <= pwdata;
                  state   <= S_WAIT;
               end
            end
            S_WAIT: begin
               if (!psel) begin
                  // Master abandoned the transfer: no response, no effects.
                  state <= S_IDLE;
               end else begin
                  state   <= S_DONE;
                  pready  <= 1'b1;
                  pslverr <= err;
                  if (!wr_q && !err)
                     prdata <= rdata;
                  if (wr_ok && !idx[2]) begin
                     reg_wr_en <= 4'b0001 << idx[1:0];
                     reg_wdata <= wdata_q;
                  end
               end
            end
            S_DONE: begin
               state   <= S_IDLE;
               pready  <= 1'b0;
               pslverr <= 1'b0;
               prdata  <= '0;
            end
            default: state <= S_IDLE;
         endcase
      end
   end

   // Event bookkeeping; a set event wins over a same-cycle W1C clear.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         frame_cnt <= 16'h0000;
         int_stat  <= 2'b00;
         int_en    <= 2'b00;
         irq       <= 1'b0;
      end else begin
         if (frame_start)
            frame_cnt <= frame_cnt + 16'd1;
         int_stat <= (int_stat & ~int_clr)
                   | {fifo_underflow, frame_start};
         if (en_wr)
            int_en <= wdata_q[1:0];
         irq <= |(int_stat & int_en);
      end
   end

endmodule

// File: tb/tb_vga_apb_regif.sv
// tb_vga_apb_regif: randomized APB traffic and event pulses against a
// transaction-level model of the VGA register interface.
module tb_vga_apb_regif;

   logic        clk;
   logic        rst_n;
   logic        psel;
   logic        penable;
   logic        pwrite;
   logic [7:0]  paddr;
   logic [31:0] pwdata;
   logic [31:0] prdata;
   logic        pready;
   logic        pslverr;
   logic [3:0]  reg_wr_en;
   logic [31:0] reg_wdata;
   logic [31:0] ctrl_q;
   logic [31:0] htim_q;
   logic [31:0] vtim_q;
   logic [31:0] base_q;
   logic        frame_start;
   logic        fifo_underflow;
   logic        irq;

   vga_apb_regif #(
      .DATA_WIDTH(32),
      .ADDR_WIDTH(8)
   ) dut (
      .clk            (clk),
      .rst_n          (rst_n),
      .psel           (psel),
      .penable        (penable),
      .pwrite         (pwrite),
      .paddr          (paddr),
      .pwdata         (pwdata),
      .prdata         (prdata),
      .pready         (pready),
      .pslverr        (pslverr),
      .reg_wr_en      (reg_wr_en),
      .reg_wdata      (reg_wdata),
      .ctrl_q         (ctrl_q),
      .htim_q         (htim_q),
      .vtim_q         (vtim_q),
      .base_q         (base_q),
      .frame_start    (frame_start),
      .fifo_underflow (fifo_underflow),
      .irq            (irq)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   int n_vec = 0;
   int n_err = 0;

   logic [15:0] m_cnt;
   logic [1:0]  m_stat;
   logic [1:0]  m_en;
   logic        m_irq;
   logic [3:0]  exp_wr_en;
   logic [1:0]  w1c_now;
   logic        en_wr_now;
   logic [1:0]  en_val;
   bit          ev_on;

   task automatic check(input string tag, input logic [31:0] got,
                        input logic [31:0] exp);
      n_vec++;
      if (got !== exp) begin
         n_err++;
         $display("FAIL %s: got %h expected %h", tag, got, exp);
      end
   endtask

   // One clock: apply the spec rules for the cycle that just ended,
   // then check the per-cycle outputs and pick new event pulses.
   task automatic step();
      logic nirq;
      @(posedge clk);
      if (rst_n) begin
         nirq = |(m_stat & m_en);
         if (frame_start)
            m_cnt = m_cnt + 16'd1;
         m_stat = (m_stat & ~w1c_now) | {fifo_underflow, frame_start};
         if (en_wr_now)
            m_en = en_val;
         m_irq = nirq;
      end
      @(negedge clk);
      check("irq", irq, m_irq);
      check("wr_en", reg_wr_en, exp_wr_en);
      frame_start    = ev_on && ($urandom_range(0, 5) == 0);
      fifo_underflow = ev_on && ($urandom_range(0, 9) == 0);
   endtask

   task automatic apb(input logic [7:0] a, input logic wr,
                      input logic [31:0] wd, input bit abort_x,
                      input bit fs_done);
      logic [31:0] exp_rd;
      logic [3:0]  stb;
      bit          err;
      paddr   = a;
      pwrite  = wr;
      pwdata  = wd;
      psel    = 1'b1;
      penable = 1'b0;
      step();
      check("wait_rdy", pready, 1'b0);
      check("wait_rd", prdata, 32'h0);
      if (abort_x) begin
         psel = 1'b0;
         step();
         check("abort_rdy", pready, 1'b0);
         check("abort_err", pslverr, 1'b0);
         return;
      end
      err = (a > 8'h18) || (a[1:0] != 2'b00) || (wr && a == 8'h10);
      exp_rd = 32'h0;
      if (!wr && !err) begin
         case (a)
            8'h00: exp_rd = ctrl_q;
            8'h04: exp_rd = htim_q;
            8'h08: exp_rd = vtim_q;
            8'h0C: exp_rd = base_q;
            8'h10: exp_rd = {16'h0, m_cnt};
            8'h14: exp_rd = {30'h0, m_stat};
            8'h18: exp_rd = {30'h0, m_en};
            default: exp_rd = 32'h0;
         endcase
      end
      stb = (wr && !err && a < 8'h10) ? (4'b0001 << a[3:2]) : 4'b0000;
      penable   = 1'b1;
      exp_wr_en = stb;
      step();
      check("done_rdy", pready, 1'b1);
      check("done_err", pslverr, err);
      check("done_rd", prdata, exp_rd);
      if (stb != 4'b0000)
         check("wdata", reg_wdata, wd);
      exp_wr_en = 4'b0000;
      w1c_now   = (wr && !err && a == 8'h14) ? wd[1:0] : 2'b00;
      en_wr_now = wr && !err && a == 8'h18;
      en_val    = wd[1:0];
      if (fs_done)
         frame_start = 1'b1;
      step();
      w1c_now   = 2'b00;
      en_wr_now = 1'b0;
      psel      = 1'b0;
      penable   = 1'b0;
      check("idle_rdy", pready, 1'b0);
      check("idle_rd", prdata, 32'h0);
      check("idle_err", pslverr, 1'b0);
      case (stb)
         4'b0001: ctrl_q = wd;
         4'b0010: htim_q = wd;
         4'b0100: vtim_q = wd;
         4'b1000: base_q = wd;
         default: ;
      endcase
   endtask

   task automatic model_reset();
      m_cnt  = 16'h0;
      m_stat = 2'b00;
      m_en   = 2'b00;
      m_irq  = 1'b0;
   endtask

   task automatic check_zero(input string tag);
      check({tag, "_rdy"}, pready, 1'b0);
      check({tag, "_err"}, pslverr, 1'b0);
      check({tag, "_rd"}, prdata, 32'h0);
      check({tag, "_wen"}, reg_wr_en, 4'b0000);
      check({tag, "_wd"}, reg_wdata, 32'h0);
      check({tag, "_irq"}, irq, 1'b0);
   endtask

   initial begin
      #5_000_000;
      $display("FAIL watchdog: simulation did not finish");
      $fatal(1);
   end

   initial begin
      logic [7:0]  a;
      logic [31:0] pos;
      rst_n          = 1'b0;
      psel           = 1'b0;
      penable        = 1'b0;
      pwrite         = 1'b0;
      paddr          = 8'h0;
      pwdata         = 32'h0;
      frame_start    = 1'b0;
      fifo_underflow = 1'b0;
      ctrl_q         = $urandom;
      htim_q         = $urandom;
      vtim_q         = $urandom;
      base_q         = $urandom;
      exp_wr_en      = 4'b0000;
      w1c_now        = 2'b00;
      en_wr_now      = 1'b0;
      en_val         = 2'b00;
      ev_on          = 1'b0;
      model_reset();
      repeat (3) @(negedge clk);
      check_zero("reset");
      rst_n = 1'b1;
      step();

      apb(8'h04, 1'b1, 32'h0000_1234, 1'b0, 1'b0);
      ctrl_q = 32'hA5A5_0001;
      apb(8'h00, 1'b0, 32'h0, 1'b0, 1'b0);
      apb(8'h20, 1'b1, 32'hDEAD_BEEF, 1'b0, 1'b0);
      apb(8'h02, 1'b0, 32'h0, 1'b0, 1'b0);
      apb(8'h10, 1'b1, 32'h1111_1111, 1'b0, 1'b0);
      apb(8'h1C, 1'b0, 32'h0, 1'b0, 1'b0);

      apb(8'h18, 1'b1, 32'h1, 1'b0, 1'b0);
      frame_start = 1'b1;
      step();
      step();
      check("irq_on_frame", irq, 1'b1);
      apb(8'h14, 1'b1, 32'h1, 1'b0, 1'b1);
      apb(8'h14, 1'b0, 32'h0, 1'b0, 1'b0);
      apb(8'h14, 1'b1, 32'h3, 1'b0, 1'b0);
      apb(8'h14, 1'b0, 32'h0, 1'b0, 1'b0);

      paddr   = 8'h08;
      pwrite  = 1'b1;
      pwdata  = 32'hCAFE_0000;
      psel    = 1'b1;
      penable = 1'b0;
      step();
      rst_n   = 1'b0;
      psel    = 1'b0;
      #1;
      check_zero("async_rst");
      model_reset();
      step();
      step();
      rst_n = 1'b1;
      step();
      check_zero("post_rst");
      apb(8'h08, 1'b1, 32'h0BAD_F00D, 1'b0, 1'b0);

      for (int i = 0; i < 65536; i++) begin
         frame_start = 1'b1;
         step();
      end
      apb(8'h10, 1'b0, 32'h0, 1'b0, 1'b0);
      apb(8'h14, 1'b1, 32'h3, 1'b0, 1'b0);

      ev_on = 1'b1;
      for (int i = 0; i < 400; i++) begin
         if ($urandom_range(0, 4) == 0) begin
            a = 8'($urandom);
         end else begin
            pos = $urandom_range(0, 6);
            a   = 8'(pos * 4);
         end
         apb(a, 1'($urandom), $urandom,
             $urandom_range(0, 15) == 0,
             $urandom_range(0, 7) == 0);
         repeat ($urandom_range(0, 2)) step();
      end

      $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
      $finish;
   end

endmodule
